// File: rtl/ttm4_fetch_sequencer.sv
// TTM4 fetch sequencer: program counter, return stack and instruction register.
// Executes one instruction per FETCH/EXEC pair in free-run or single-step mode.
module ttm4_fetch_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned STK_D = 4,
  parameter int unsigned SP_W  = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RUN,
  input  logic            STEP,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic [10:0]     IMEM_DATA,
  output logic [4:0]      OP,
  output logic [2:0]      LR,
  output logic [2:0]      SR,
  output logic            EXEC,
  input  logic            nPC_LD,
  input  logic            nSK_EN,
  input  logic            SP_D_nU,
  input  logic [PC_W-1:0] JMP_ADDR,
  output logic [SP_W-1:0] SP,
  output logic            STK_ERR,
  output logic            HALTED
);

  localparam int unsigned IdxW = SP_W - 1;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [10:0]     ir_q, ir_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [PC_W-1:0] stk_q [STK_D];
  logic [PC_W-1:0] stk_d [STK_D];
  logic            err_q, err_d;
  logic            step_q, step_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    stk_d   = stk_q;
    err_d   = err_q;
    step_d  = STEP;
    unique case (state_q)
      StIdle: begin
        if (RUN || (STEP && !step_q)) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = IMEM_DATA;
        state_d = StExec;
      end
      StExec: begin
        state_d = RUN ? StFetch : StIdle;
        // Stack operations win over a plain jump when both are requested.
        if (!nSK_EN && !SP_D_nU) begin
          if (sp_q == SP_W'(STK_D)) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end else begin
            stk_d[sp_q[IdxW-1:0]] = pc_inc;
            sp_d                  = sp_q + 1'b1;
            pc_d                  = JMP_ADDR;
          end
        end else if (!nSK_EN) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d = stk_q[sp_q[IdxW-1:0] - 1'b1];
            sp_d = sp_q - 1'b1;
          end
        end else if (!nPC_LD) begin
          pc_d = JMP_ADDR;
        end else begin
          pc_d = pc_inc;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      sp_q    <= '0;
      stk_q   <= '{default: '0};
      err_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      stk_q   <= stk_d;
      err_q   <= err_d;
      step_q  <= step_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign OP        = ir_q[10:6];
  assign LR        = ir_q[5:3];
  assign SR        = ir_q[2:0];
  assign EXEC      = (state_q == StExec);
  assign HALTED    = (state_q == StHalt);
  assign SP        = sp_q;
  assign STK_ERR   = err_q;

endmodule

// File: doc/ttm4_fetch_sequencer.md
Name: ttm4_fetch_sequencer

Overview:
- Upstream stage of the TTM4 instruction decoder.
- Holds the program counter (PC) and a hardware return stack, and fetches 11-bit instruction words from program memory into an instruction register.
- Presents the OP/LR/SR fields to the decoder.
- Consumes the decoder's nPC_LD, nSK_EN and SP_D_nU controls to compute the next PC.
- Supports free-run and single-step operation for the emulator front panel.

Parameters:
- PC_W, 8: PC and jump-address width; PC wraps modulo 2^PC_W.
- STK_D, 4: return-stack depth in entries (power of 2, at least 2).
- SP_W, 3: stack-pointer width; must equal clog2(STK_D)+1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  level; 1 = free-run.
- STEP  in  1  single-step request; rising edge detected internally.
- IMEM_ADDR  out  PC_W  program-memory address; always equals PC.
- IMEM_DATA  in  11  instruction word, combinational read of IMEM_ADDR; bits [10:6]=OP, [5:3]=LR, [2:0]=SR.
- OP  out  5  instruction-register opcode field.
- LR  out  3  load-register field.
- SR  out  3  store-register field.
- EXEC  out  1  high during the EXEC state; decoder outputs are consumed in this cycle only.
- nPC_LD  in  1  active-low jump request from the decoder.
- nSK_EN  in  1  active-low stack-operation enable from the decoder.
- SP_D_nU  in  1  stack direction: 0 = push/call, 1 = pop/return.
- JMP_ADDR  in  PC_W  jump/call target from the jump register.
- SP  out  SP_W  number of occupied stack entries.
- STK_ERR  out  1  sticky stack overflow/underflow flag.
- HALTED  out  1  high in the HALT state.

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, PC=0, IR=0 (OP/LR/SR=0), SP=0, stack contents=0, STK_ERR=0, EXEC=0, HALTED=0, step edge detector cleared.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - RUN=1 -> FETCH.
  - Else a STEP rising edge (STEP=1 and previous-cycle STEP=0) -> FETCH.
  - Else stay in IDLE.
- FETCH: IR <= IMEM_DATA -> EXEC. The PC is unchanged.
- EXEC: EXEC=1 and the PC is updated by priority:
  1. nSK_EN=0, SP_D_nU=0 (call):
     - If SP==STK_D: overflow; STK_ERR<=1 -> HALT, with PC, SP and stack unchanged.
     - Else stack[SP] <= PC+1 (wrapped), SP <= SP+1, PC <= JMP_ADDR.
  2. nSK_EN=0, SP_D_nU=1 (return):
     - If SP==0: underflow; STK_ERR<=1 -> HALT, with nothing changed.
     - Else PC <= stack[SP-1], SP <= SP-1.
  3. nPC_LD=0: PC <= JMP_ADDR.
  4. Otherwise: PC <= PC+1, modulo 2^PC_W (PC=2^PC_W-1 wraps to 0).
- Next state from a non-error EXEC: FETCH if RUN=1, else IDLE.
- nSK_EN=0 has priority over nPC_LD=0 when both are asserted.
- Control inputs are ignored outside EXEC.
- Latency: 2 cycles per instruction. Free-run throughput is one instruction per 2 CLK cycles.
- Single step: one STEP rising edge executes exactly one instruction. STEP held high does not repeat. STEP is ignored while RUN=1 or outside IDLE; edge detection is still sampled every cycle.
- RUN deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- HALT: terminal until RST. HALTED=1, EXEC=0, outputs are frozen, RUN/STEP are ignored.
- SP and STK_ERR are registered outputs. IMEM_ADDR is PC directly, with no added latency.

Test Plan:
- Sequential fetch: reset, IMEM all NOPs (decoder controls inactive), RUN=1 for 20 cycles -> IMEM_ADDR steps 0,1,...,9 at 2-cycle spacing; EXEC pulses every second cycle.
- Jump with priority: in EXEC with nPC_LD=0, nSK_EN=1, JMP_ADDR=0x3C -> next IMEM_ADDR=0x3C. Repeat with nPC_LD=0 and nSK_EN=0, SP_D_nU=0 -> a call is taken and SP=1.
- Call/return: call at PC=0x05 to 0x40, then return at 0x42 -> stack[0]=0x06, SP goes 1 then 0, and PC after the return is 0x06.
- Overflow: 4 nested calls (SP=4), then a 5th call -> STK_ERR=1, HALTED=1, PC and SP=4 unchanged; further RUN/STEP have no effect until RST clears everything to 0.
- Underflow and wrap: a return with SP=0 -> STK_ERR=1, HALT. Separately, PC=0xFF with no control -> next PC=0x00.
- Single-step and reset: RUN=0, STEP held high for 10 cycles -> exactly one EXEC pulse and PC advances by 1. RST asserted during EXEC -> all outputs are 0 immediately, without waiting for a CLK edge.
